// File: rtl/regdemux_n_pkg.sv
// Shared definitions for the regdemux_n register demultiplexer.
//   RSA_DW_DEF : default per-channel data width
//   mode_e     : auto_mode encodings (MODE_MANUAL / MODE_AUTO)
//   sel_w()    : select/pointer width for a given channel count, never below 1
package regdemux_n_pkg;

    localparam int RSA_DW_DEF = 16;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regdemux_ptr.sv
// Auto-routing pointer for regdemux_n.
//   clk, sys_rst : clock, synchronous active-high reset
//   step         : an auto-mode beat is accepted this cycle
//   load         : start in auto mode; replace the pointer with load_val
//   load_val     : value to load; values >= N_OUT load 0 instead
//   ptr          : pointer in effect this cycle (already reflects a same-cycle load)
//   wrap         : this cycle's beat targets channel N_OUT-1, so the pointer wraps
//   load_err     : load_val was out of range
module regdemux_ptr
    import regdemux_n_pkg::*;
#(
    parameter int N_OUT = 4,
    localparam int SEL_W = sel_w(N_OUT)
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             step,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    output logic [SEL_W-1:0] ptr,
    output logic             wrap,
    output logic             load_err
);

    logic [SEL_W-1:0] ptr_q;

    // A load is visible to the beat of the same cycle, so the effective
    // pointer is resolved combinationally ahead of the register.
    always_comb begin
        load_err = load && (32'(load_val) >= N_OUT);
        ptr      = ptr_q;
        if (load)
            ptr = load_err ? '0 : load_val;
        wrap = step && (32'(ptr) == N_OUT - 1);
    end

    always_ff @(posedge clk) begin
        if (sys_rst)
            ptr_q <= '0;
        else if (step)
            ptr_q <= wrap ? '0 : ptr + SEL_W'(1);
        else if (load)
            ptr_q <= ptr;
    end

endmodule

// File: rtl/regdemux_n.sv
// Registered 1-to-N_OUT demultiplexer with manual (sel) or auto (pointer) routing.
//   clk, sys_rst : clock, synchronous active-high reset
//   en           : block enable; when low, pulses are 0 and dout clears or holds per CLR_ON_IDLE
//   auto_mode    : MODE_MANUAL routes by sel, MODE_AUTO routes by the internal pointer
//   start        : in auto mode, loads the pointer from sel
//   sel          : manual channel select / pointer load value
//   din_vld, din : input beat
//   dout         : channel k at [k*RSA_DW +: RSA_DW]
//   dout_vld     : one-hot, channel written this cycle
//   frame_done   : pulses with the write to channel N_OUT-1 in auto mode
//   sel_err      : pulses when a beat or pointer load targets a channel >= N_OUT
module regdemux_n
    import regdemux_n_pkg::*;
#(
    parameter int RSA_DW      = RSA_DW_DEF,
    parameter int N_OUT       = 4,
    parameter bit CLR_ON_IDLE = 1'b1,
    localparam int SEL_W      = sel_w(N_OUT)
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic                    en,
    input  logic                    auto_mode,
    input  logic                    start,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    din_vld,
    input  logic [RSA_DW-1:0]       din,
    output logic [N_OUT*RSA_DW-1:0] dout,
    output logic [N_OUT-1:0]        dout_vld,
    output logic                    frame_done,
    output logic                    sel_err
);

    logic             is_auto;
    logic             accept;
    logic [SEL_W-1:0] ptr;
    logic             wrap;
    logic             load_err;
    logic [SEL_W-1:0] tgt;
    logic             tgt_ok;

    assign is_auto = (mode_e'(auto_mode) == MODE_AUTO);
    assign accept  = en && din_vld;

    regdemux_ptr #(.N_OUT(N_OUT)) u_ptr (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .step     (accept && is_auto),
        .load     (en && is_auto && start),
        .load_val (sel),
        .ptr      (ptr),
        .wrap     (wrap),
        .load_err (load_err)
    );

    assign tgt    = is_auto ? ptr : sel;
    assign tgt_ok = (32'(tgt) < N_OUT);

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            dout       <= '0;
            dout_vld   <= '0;
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            dout_vld   <= '0;
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
            if (!en) begin
                if (CLR_ON_IDLE)
                    dout <= '0;
            end else begin
                if (load_err)
                    sel_err <= 1'b1;
                if (accept) begin
                    if (tgt_ok) begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (32'(tgt) == k) begin
                                dout[k*RSA_DW +: RSA_DW] <= din;
                                dout_vld[k]              <= 1'b1;
                            end
                        end
                        frame_done <= wrap;
                    end else begin
                        sel_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regdemux_n.sv
// Two instances share one stimulus stream:
//   DUT A: N_OUT=4, CLR_ON_IDLE=1    DUT B: N_OUT=3, CLR_ON_IDLE=0
// A behavioural model (per-channel arrays plus an integer pointer) predicts
// every output after each rising edge.
module tb_regdemux_n;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          sys_rst, en, auto_mode, start, din_vld;
    logic [1:0]    sel;
    logic [DW-1:0] din;

    logic [4*DW-1:0] dout_a;
    logic [3:0]      vld_a;
    logic            fd_a, err_a;
    logic [3*DW-1:0] dout_b;
    logic [2:0]      vld_b;
    logic            fd_b, err_b;

    always #5 clk = ~clk;

    regdemux_n #(.RSA_DW(DW), .N_OUT(4), .CLR_ON_IDLE(1'b1)) u_a (
        .clk(clk), .sys_rst(sys_rst), .en(en), .auto_mode(auto_mode), .start(start),
        .sel(sel), .din_vld(din_vld), .din(din),
        .dout(dout_a), .dout_vld(vld_a), .frame_done(fd_a), .sel_err(err_a));

    regdemux_n #(.RSA_DW(DW), .N_OUT(3), .CLR_ON_IDLE(1'b0)) u_b (
        .clk(clk), .sys_rst(sys_rst), .en(en), .auto_mode(auto_mode), .start(start),
        .sel(sel), .din_vld(din_vld), .din(din),
        .dout(dout_b), .dout_vld(vld_b), .frame_done(fd_b), .sel_err(err_b));

    int errors = 0;
    int checks = 0;

    // model state, index 0 = DUT A, 1 = DUT B
    int      nout [2] = '{4, 3};
    bit      clr  [2] = '{1'b1, 1'b0};
    int      mptr [2];
    int      mdout[2][4];
    int      mvld [2];
    bit      mfd  [2];
    bit      merr [2];

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int n = nout[d];
            mvld[d] = 0; mfd[d] = 0; merr[d] = 0;
            if (sys_rst) begin
                mptr[d] = 0;
                for (int k = 0; k < 4; k++) mdout[d][k] = 0;
            end else if (!en) begin
                if (clr[d]) for (int k = 0; k < 4; k++) mdout[d][k] = 0;
            end else begin
                int p = mptr[d];
                int s = int'(sel);
                if (auto_mode && start) begin
                    if (s >= n) begin p = 0; merr[d] = 1; end
                    else p = s;
                end
                if (din_vld) begin
                    int t = auto_mode ? p : s;
                    if (t < n) begin
                        mdout[d][t] = int'(din);
                        mvld[d] = 1 << t;
                        if (auto_mode) begin
                            mfd[d] = (t == n - 1);
                            p = (t + 1) % n;
                        end
                    end else merr[d] = 1;
                end
                if (auto_mode) mptr[d] = p;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s A.dout%0d", tag, k), 64'(dout_a[k*DW +: DW]), 64'(mdout[0][k]));
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s B.dout%0d", tag, k), 64'(dout_b[k*DW +: DW]), 64'(mdout[1][k]));
        chk({tag, " A.vld"}, 64'(vld_a), 64'(mvld[0]));
        chk({tag, " B.vld"}, 64'(vld_b), 64'(mvld[1]));
        chk({tag, " A.fd"},  64'(fd_a),  64'(mfd[0]));
        chk({tag, " B.fd"},  64'(fd_b),  64'(mfd[1]));
        chk({tag, " A.err"}, 64'(err_a), 64'(merr[0]));
        chk({tag, " B.err"}, 64'(err_b), 64'(merr[1]));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit r, input bit e, input bit a, input bit st,
                         input int s, input bit v, input int d);
        sys_rst = r; en = e; auto_mode = a; start = st;
        sel = 2'(s); din_vld = v; din = DW'(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mptr[d] = 0;
            for (int k = 0; k < 4; k++) mdout[d][k] = 0;
        end
        // reset
        drive(1, 1, 0, 0, 0, 1, 16'hDEAD);
        tick("rst0");
        tick("rst1");
        chk("rst A.dout all", 64'(dout_a), 64'h0);

        // manual write sel=2
        drive(0, 1, 0, 0, 2, 1, 16'h1234);
        tick("man2");
        chk("man2 A.ch2 const", 64'(dout_a[2*DW +: DW]), 64'h1234);
        chk("man2 A.vld const", 64'(vld_a), 64'b0100);
        drive(0, 1, 0, 0, 0, 0, 0);
        tick("idle_vld0");

        // auto: start sel=0 then 5 beats A0..A4
        drive(0, 1, 1, 1, 0, 0, 0);
        tick("auto_start");
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 0, 0, 1, 16'hA0 + i);
            tick($sformatf("auto%0d", i));
            chk($sformatf("auto%0d A.fd const", i), 64'(fd_a), 64'(i == 3));
        end
        chk("auto A.ch0 const", 64'(dout_a[0 +: DW]), 64'hA4);

        // start + beat same cycle, sel=3 (out of range for B)
        drive(0, 1, 1, 1, 3, 1, 16'h55);
        tick("stbeat");
        chk("stbeat A.ch3 const", 64'(dout_a[3*DW +: DW]), 64'h55);
        chk("stbeat A.fd const", 64'(fd_a), 64'h1);
        chk("stbeat B.err const", 64'(err_b), 64'h1);
        drive(0, 1, 1, 0, 0, 1, 16'h66);
        tick("stbeat_next");
        chk("stbeat_next A.vld const", 64'(vld_a), 64'b0001);

        // manual out-of-range for B
        drive(0, 1, 0, 0, 3, 1, 16'hFF);
        tick("oor");
        chk("oor B.vld const", 64'(vld_b), 64'h0);

        // load all channels manually, then idle 2 cycles
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, i, 1, 16'hC0 + i);
            tick($sformatf("load%0d", i));
        end
        drive(0, 0, 1, 1, 1, 1, 16'hBAD);
        tick("idle0");
        tick("idle1");
        chk("idle A.dout const", 64'(dout_a), 64'h0);
        chk("idle B.ch1 const", 64'(dout_b[DW +: DW]), 64'hC1);
        // pointer preserved across idle: continue auto without start
        drive(0, 1, 1, 0, 0, 1, 16'h77);
        tick("after_idle");

        // reset mid-frame
        drive(0, 1, 1, 1, 0, 1, 16'h11);
        tick("mf0");
        drive(0, 1, 1, 0, 0, 1, 16'h12);
        tick("mf1");
        drive(1, 1, 1, 0, 0, 1, 16'h13);
        tick("mf_rst");
        chk("mf_rst A.dout const", 64'(dout_a), 64'h0);
        drive(0, 1, 1, 0, 0, 1, 16'h14);
        tick("mf_after");
        chk("mf_after A.vld const", 64'(vld_a), 64'b0001);

        // randomized phase
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
                  (i / 25) % 2 == 1 ? $urandom_range(0, 7) != 0 : $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 16'hFFFF));
            tick($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
